// File: rtl/calc_pkg.sv
// calc_pkg: symbol encodings, token/error enums and ROM sizing shared by the expression front end and the evaluator.
package calc_pkg;
    localparam int DEF_DEPTH = 100;
    localparam int DEF_IDX_W = 7;
    localparam logic [7:0] SYM_END = 8'd10;
    localparam logic [7:0] SYM_ADD = 8'd20;
    localparam logic [7:0] SYM_SUB = 8'd21;
    localparam logic [7:0] SYM_MUL = 8'd22;
    localparam logic [7:0] SYM_DIV = 8'd23;
    typedef enum logic [1:0] {TOK_NUMBER, TOK_OPERATOR, TOK_END} tok_kind_t;
    typedef enum logic [1:0] {ERR_BAD_SYMBOL, ERR_EMPTY_OPERAND, ERR_OVERFLOW, ERR_NO_TERMINATOR} err_code_t;
endpackage

// File: rtl/dec_accum.sv
// dec_accum: combinational acc*10+digit with overflow flag.
module dec_accum #(
    parameter int NUM_W = 16
) (
    input  logic [NUM_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [NUM_W-1:0] sum,
    output logic             ovf
);
    // Four extra bits always hold 10*(2^NUM_W-1)+9, so the top nibble flags overflow exactly.
    logic [NUM_W+3:0] wide;
    assign wide = {4'b0, acc} * (NUM_W+4)'(10) + (NUM_W+4)'(digit);
    assign sum  = wide[NUM_W-1:0];
    assign ovf  = |wide[NUM_W+3:NUM_W];
endmodule

// File: rtl/expr_token_sequencer.sv
// expr_token_sequencer: scans the expression ROM up to '#', packs digits into numbers and streams NUMBER/OPERATOR/END tokens.
module expr_token_sequencer
    import calc_pkg::*;
#(
    parameter int NUM_W = 16,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] rom_index,
    input  logic [7:0]       rom_data,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [1:0]       tok_kind,
    output logic [NUM_W-1:0] tok_value,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [IDX_W-1:0] err_index
);
    typedef enum logic [2:0] {IDLE, SCAN, EMIT_NUM, EMIT_OP, EMIT_END, DONE, ERR} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] idx, idx_n, eidx_n;
    logic [NUM_W-1:0] acc, acc_n, acc_sum, tval_n;
    logic [1:0] op_pend, op_n, code_n;
    logic have_num, have_n, end_pend, end_n, done_n, error_n, ovf, fire;
    logic is_digit, is_op, is_end, last, past;
    dec_accum #(.NUM_W(NUM_W)) u_acc (.acc(acc), .digit(rom_data[3:0]), .sum(acc_sum), .ovf(ovf));
    assign rom_index = idx;
    assign busy      = state inside {SCAN, EMIT_NUM, EMIT_OP, EMIT_END};
    assign fire      = tok_valid && tok_ready;
    assign is_digit  = rom_data <= 8'd9;
    assign is_end    = rom_data == SYM_END;
    assign is_op     = rom_data >= SYM_ADD && rom_data <= SYM_DIV;
    assign last      = idx == IDX_W'(DEPTH-1);
    assign past      = idx > IDX_W'(DEPTH-1);
    always_comb begin
        state_n = state;
        idx_n   = idx;
        acc_n   = acc;
        have_n  = have_num;
        op_n    = op_pend;
        end_n   = end_pend;
        done_n  = done;
        error_n = error;
        code_n  = err_code;
        eidx_n  = err_index;
        case (state)
            IDLE, DONE, ERR: if (start) begin
                state_n = SCAN;
                idx_n   = '0;
                acc_n   = '0;
                have_n  = 1'b0;
                end_n   = 1'b0;
                done_n  = 1'b0;
                error_n = 1'b0;
                code_n  = 2'd0;
                eidx_n  = '0;
            end
            SCAN: begin
                if (is_digit && !(past || last || ovf)) begin
                    acc_n  = acc_sum;
                    have_n = 1'b1;
                    idx_n  = idx + IDX_W'(1);
                end else if ((is_op || is_end) && have_num && !past) begin
                    state_n = EMIT_NUM;
                    op_n    = rom_data[1:0];
                    end_n   = is_end;
                end else begin
                    state_n = ERR;
                    error_n = 1'b1;
                    eidx_n  = idx;
                    code_n  = (past || (is_digit && last)) ? ERR_NO_TERMINATOR :
                              is_digit ? ERR_OVERFLOW :
                              (is_op || is_end) ? ERR_EMPTY_OPERAND : ERR_BAD_SYMBOL;
                end
            end
            EMIT_NUM: if (fire) state_n = end_pend ? EMIT_END : EMIT_OP;
            EMIT_OP: if (fire) begin
                state_n = SCAN;
                acc_n   = '0;
                have_n  = 1'b0;
                idx_n   = idx + IDX_W'(1);
            end
            EMIT_END: if (fire) begin
                state_n = DONE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // Token fields are registered from the next state so they stay frozen while stalled.
        tval_n = state_n == EMIT_NUM ? acc_n : state_n == EMIT_OP ? NUM_W'(op_n) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            have_num  <= 1'b0;
            op_pend   <= 2'd0;
            end_pend  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'd0;
            err_index <= '0;
            tok_valid <= 1'b0;
            tok_kind  <= 2'd0;
            tok_value <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            acc       <= acc_n;
            have_num  <= have_n;
            op_pend   <= op_n;
            end_pend  <= end_n;
            done      <= done_n;
            error     <= error_n;
            err_code  <= code_n;
            err_index <= eidx_n;
            tok_valid <= state_n inside {EMIT_NUM, EMIT_OP, EMIT_END};
            tok_kind  <= state_n == EMIT_OP ? TOK_OPERATOR : state_n == EMIT_END ? TOK_END : TOK_NUMBER;
            tok_value <= tval_n;
        end
    end
endmodule

// File: tb/tb_expr_token_sequencer.sv
// tb_expr_token_sequencer: table-driven token-stream checks with a scoreboard queue, plus reset and restart sequences.
module tb_expr_token_sequencer;
    import calc_pkg::*;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0, sel = 1'b0;
    always #5 clk = ~clk;
    logic [7:0] rom [0:99];
    logic [6:0] i16, i8, x16, x8, ei;
    logic [7:0] d16, d8, val8;
    logic [15:0] val16, tval;
    logic [1:0] k16, k8, c16, c8, tk, ec;
    logic v16, v8, b16, b8, dn16, dn8, e16, e8, tv, bz, dn, er;
    assign d16 = i16 < 7'd100 ? rom[i16] : 8'd10;
    assign d8  = i8 < 7'd100 ? rom[i8] : 8'd10;
    expr_token_sequencer #(.NUM_W(16)) u16 (.clk(clk), .rst(rst), .start(start && !sel), .rom_index(i16),
        .rom_data(d16), .tok_valid(v16), .tok_ready(ready), .tok_kind(k16), .tok_value(val16), .busy(b16),
        .done(dn16), .error(e16), .err_code(c16), .err_index(x16));
    expr_token_sequencer #(.NUM_W(8)) u8 (.clk(clk), .rst(rst), .start(start && sel), .rom_index(i8),
        .rom_data(d8), .tok_valid(v8), .tok_ready(ready), .tok_kind(k8), .tok_value(val8), .busy(b8),
        .done(dn8), .error(e8), .err_code(c8), .err_index(x8));
    assign tv   = sel ? v8 : v16;
    assign bz   = sel ? b8 : b16;
    assign dn   = sel ? dn8 : dn16;
    assign er   = sel ? e8 : e16;
    assign tk   = sel ? k8 : k16;
    assign ec   = sel ? c8 : c16;
    assign ei   = sel ? x8 : x16;
    assign tval = sel ? {8'd0, val8} : val16;

    int tests = 0, fails = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {logic [1:0] kind; logic [15:0] value;} tok_t;
    tok_t q[$];
    typedef struct {
        logic [0:7][7:0]  rom;
        logic [7:0]       fill;
        bit               narrow;
        bit               stall;
        int               ntok;
        logic [0:3][17:0] toks;
        bit               err;
        logic [1:0]       code;
        int               eidx;
    } vec_t;
    vec_t vecs[10];

    function automatic logic [17:0] tok(input logic [1:0] k, input logic [15:0] v);
        return {k, v};
    endfunction

    task automatic run(input vec_t v);
        bit fin, stalled;
        int hold;
        tok_t held, e;
        sel = v.narrow;
        for (int i = 0; i < 100; i++) rom[i] = i < 8 ? v.rom[i] : v.fill;
        for (int i = 0; i < v.ntok; i++) q.push_back(tok_t'(v.toks[i]));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        fin = 1'b0; stalled = 1'b0; hold = 0; held = '0;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (!bz) fin = 1'b1;
            else begin
                // A start pulse mid-scan must be ignored.
                start = (c == 2);
                if (stalled) begin
                    chk("stall_valid", tv, 1);
                    chk("stall_kind", tk, held.kind);
                    chk("stall_value", tval, held.value);
                end
                ready = !v.stall || hold >= 3;
                hold = tv ? hold + 1 : 0;
                stalled = tv && !ready;
                held = '{tk, tval};
                if (tv && ready) begin
                    hold = 0;
                    if (q.size() == 0) chk("extra_token", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("tok_kind", tk, e.kind);
                        chk("tok_value", tval, e.value);
                    end
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("scan_finished", fin, 1);
        chk("valid_after", tv, 0);
        chk("done_flag", dn, !v.err);
        chk("error_flag", er, v.err);
        if (v.err) begin
            chk("err_code", ec, v.code);
            chk("err_index", ei, v.eidx);
        end
        chk("missing_tokens", q.size(), 0);
        q.delete();
    endtask

    initial begin
        vecs[0] = '{{8'd5, 8'd5, 8'd20, 8'd1, 8'd1, 8'd10, 8'd10, 8'd10}, 8'd10, 1'b0, 1'b0, 4,
                    {tok(2'd0, 16'd55), tok(2'd1, 16'd0), tok(2'd0, 16'd11), tok(2'd2, 16'd0)}, 1'b0, 2'd0, 0};
        vecs[1] = vecs[0];
        vecs[1].stall = 1'b1;
        vecs[2] = '{{8'd20, 8'd1, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 8'd10, 1'b0, 1'b0, 0,
                    {4{18'd0}}, 1'b1, 2'd1, 0};
        vecs[3] = '{{8'd3, 8'd21, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 8'd10, 1'b0, 1'b0, 2,
                    {tok(2'd0, 16'd3), tok(2'd1, 16'd1), 36'd0}, 1'b1, 2'd1, 2};
        vecs[4] = '{{8'd2, 8'd5, 8'd6, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 8'd10, 1'b1, 1'b0, 0,
                    {4{18'd0}}, 1'b1, 2'd2, 2};
        vecs[5] = '{{8'd2, 8'd5, 8'd5, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 8'd10, 1'b1, 1'b0, 2,
                    {tok(2'd0, 16'd255), tok(2'd2, 16'd0), 36'd0}, 1'b0, 2'd0, 0};
        vecs[6] = '{{8'd1, 8'd15, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 8'd10, 1'b0, 1'b0, 0,
                    {4{18'd0}}, 1'b1, 2'd0, 1};
        vecs[7] = '{{8'd0, 8'd0, 8'd7, 8'd22, 8'd1, 8'd2, 8'd10, 8'd10}, 8'd10, 1'b0, 1'b1, 4,
                    {tok(2'd0, 16'd7), tok(2'd1, 16'd2), tok(2'd0, 16'd12), tok(2'd2, 16'd0)}, 1'b0, 2'd0, 0};
        vecs[8] = '{{8'd9, 8'd23, 8'd8, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 8'd10, 1'b0, 1'b0, 4,
                    {tok(2'd0, 16'd9), tok(2'd1, 16'd3), tok(2'd0, 16'd8), tok(2'd2, 16'd0)}, 1'b0, 2'd0, 0};
        vecs[9] = '{{8{8'd0}}, 8'd0, 1'b0, 1'b0, 0, {4{18'd0}}, 1'b1, 2'd3, 99};
        repeat (2) @(negedge clk);
        chk("reset_outputs_16", |{v16, b16, dn16, e16, k16, c16, val16, x16, i16}, 0);
        chk("reset_outputs_8", |{v8, b8, dn8, e8, k8, c8, val8, x8, i8}, 0);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) run(vecs[n]);
        // Stall the first NUMBER token, then hit it with an asynchronous reset.
        sel = 1'b0;
        for (int i = 0; i < 100; i++) rom[i] = i < 8 ? vecs[0].rom[i] : 8'd10;
        ready = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 20 && !tv; c++) @(negedge clk);
        chk("stall_reached", tv, 1);
        #2 rst = 1'b1;
        #1 chk("async_reset", |{v16, b16, dn16, e16, k16, c16, val16, x16, i16}, 0);
        @(negedge clk) rst = 1'b0;
        run(vecs[0]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/expr_token_sequencer.md
Name: expr_token_sequencer

Overview:
Walks the expression ROM from index 0 up to the '#' terminator, one symbol per cycle. Packs consecutive decimal digits into numbers and checks token order. Emits a clean token stream (NUMBER / OPERATOR / END) over a valid/ready handshake to the downstream evaluator. It is the sole driver of the ROM index bus and sits between the expression ROM and the calculator ALU/stack.

Parameters:
NUM_W, 16, width of accumulated operand value
DEPTH, 100, number of ROM entries; scanning past DEPTH-1 is an error
IDX_W, 7, width of ROM index

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse: begin scan at index 0; ignored while busy
rom_index  out  IDX_W  address to expression ROM (combinational read)
rom_data  in  8  symbol at rom_index, valid same cycle
tok_valid  out  1  token available
tok_ready  in  1  downstream accepts token when tok_valid && tok_ready
tok_kind  out  2  0=NUMBER, 1=OPERATOR, 2=END
tok_value  out  NUM_W  number value, or op code 0..3 zero-extended; 0 for END
busy  out  1  scan in progress
done  out  1  sticky: END accepted; cleared on next accepted start
error  out  1  sticky: scan aborted; cleared on next accepted start
err_code  out  2  0=BAD_SYMBOL, 1=EMPTY_OPERAND, 2=OVERFLOW, 3=NO_TERMINATOR
err_index  out  IDX_W  rom_index at which the error was detected

Behaviour:
- Symbol encoding: 0..9 digit; 10 '#' terminator; 20 '+', 21 '-', 22 '*', 23 '/' (op code = symbol-20); any other value is BAD_SYMBOL.
- Reset: state IDLE; all outputs 0; internal idx/acc/have_num/op_pend cleared. Reset asserted mid-scan aborts immediately; no token is completed.
- IDLE: when start=1, clear idx, acc, have_num, done, error, err_code, err_index; go to SCAN next cycle. busy=1 in every state except IDLE, DONE and ERR.
- SCAN (one ROM symbol per cycle, rom_index=idx):
  - digit d: acc <= acc*10+d; have_num <= 1; idx++. If the result exceeds 2^NUM_W-1, go to ERR with OVERFLOW.
  - operator: if !have_num, go to ERR with EMPTY_OPERAND. Otherwise latch op_pend and go to EMIT_NUM.
  - terminator: if !have_num, go to ERR with EMPTY_OPERAND. This covers an empty expression and a trailing operator. Otherwise go to EMIT_NUM with end_pend=1.
  - bad symbol: go to ERR with BAD_SYMBOL.
  - if idx = DEPTH-1 and the symbol is a digit, go to ERR with NO_TERMINATOR.
- EMIT_NUM: tok_valid=1, kind NUMBER, value acc. On handshake, go to EMIT_END if end_pend, else EMIT_OP.
- EMIT_OP: kind OPERATOR, value op_pend. On handshake: acc<=0, have_num<=0, idx++, back to SCAN.
- EMIT_END: kind END. On handshake: done<=1, go to DONE.
- DONE/ERR: hold flags; rom_index holds its last value; accept start exactly as in IDLE.
- Handshake: while tok_valid && !tok_ready, tok_kind and tok_value are stable and tok_valid stays high. Tokens are never dropped and never duplicated. tok_valid is registered.
- Timing: the first ROM read is the cycle after start. The number token appears on tok_valid the cycle after its delimiter is read. With tok_ready held high, each operator costs 3 cycles (scan, num, op).
- Arithmetic: acc*10 is computed at NUM_W+4 bits for the overflow check. Leading zeros are legal ("007" = 7).

Decomposition:
- Shared package calc_pkg holds: symbol constants (SYM_END=10, SYM_ADD=20..SYM_DIV=23), tok_kind enum, err_code enum, and the DEPTH/IDX_W defaults. The downstream evaluator reuses it.
- One natural sub-module: dec_accum (acc*10+d with overflow flag), purely combinational.
- The FSM stays in expr_token_sequencer.

Test Plan:
- ROM "5,5,20,1,1,10", tok_ready=1, start -> tokens NUMBER 55, OPERATOR 0, NUMBER 11, END. done=1, error=0, busy drops after END accepted.
- Same ROM, tok_ready low for 3 cycles on each token -> identical token sequence, tok_kind/tok_value stable while stalled, no duplicates.
- ROM "20,1,10" -> error=1, err_code=EMPTY_OPERAND, err_index=0, no tokens emitted. ROM "3,21,10" -> NUMBER 3, OPERATOR 1, then EMPTY_OPERAND at index 2.
- NUM_W=8, ROM "2,5,6,10" -> OVERFLOW at index 2. ROM "2,5,5,10" -> NUMBER 255, END.
- ROM "1,15,10" -> BAD_SYMBOL at index 1. All-digit ROM of DEPTH entries -> NO_TERMINATOR at index DEPTH-1.
- Assert rst while a NUMBER token is stalled -> all outputs 0 asynchronously. A new start after reset replays the full stream from index 0; start pulsed while busy has no effect.
